// File: rtl/z80_bus_bridge.sv
// Bridge from the Z80 pin-level bus to a synchronous single-port RAM and a handshaked
// 8-bit I/O port, with nWAIT stretching and interrupt-acknowledge vector return.
module z80_bus_bridge #(
    parameter int unsigned MEM_WAIT   = 0,
    parameter int unsigned IO_TIMEOUT = 16,
    parameter logic [7:0]  INT_VECTOR = 8'hFF
) (
    input  logic        CLK,
    input  logic        nRESET,
    input  logic [15:0] A,
    input  logic [7:0]  D_in,
    output logic [7:0]  D_out,
    output logic        D_oe,
    input  logic        nM1,
    input  logic        nMREQ,
    input  logic        nIORQ,
    input  logic        nRD,
    input  logic        nWR,
    input  logic        nRFSH,
    output logic        nWAIT,
    output logic [15:0] ram_addr,
    output logic        ram_re,
    output logic        ram_we,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata,
    output logic        io_req,
    output logic        io_wr,
    output logic [7:0]  io_addr,
    output logic [7:0]  io_wdata,
    input  logic [7:0]  io_rdata,
    input  logic        io_ack
);
    localparam logic [3:0] WaitInit    = 4'(MEM_WAIT);
    localparam logic [7:0] TimeoutInit = 8'(IO_TIMEOUT);

    typedef enum logic [2:0] {StIdle, StMemWait, StRdLat, StIo, StHold} stateT;

    stateT      state;
    logic [3:0] wcnt;
    logic [7:0] timer;
    logic       isRead;

    logic inta, mrd, mwr, iord, iowr, busIdle;

    always_comb begin
        inta    = !nM1 && !nIORQ;
        mrd     = !nMREQ && !nRD && nRFSH;
        mwr     = !nMREQ && !nWR && nRFSH;
        iord    = !nIORQ && nM1 && !nRD;
        iowr    = !nIORQ && nM1 && !nWR;
        busIdle = nMREQ && nIORQ && nRD && nWR;
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state     <= StIdle;
            nWAIT     <= 1'b1;
            D_oe      <= 1'b0;
            D_out     <= 8'h00;
            ram_re    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= 16'h0000;
            ram_wdata <= 8'h00;
            io_req    <= 1'b0;
            io_wr     <= 1'b0;
            io_addr   <= 8'h00;
            io_wdata  <= 8'h00;
            wcnt      <= 4'd0;
            timer     <= 8'd0;
            isRead    <= 1'b0;
        end else begin
            ram_re <= 1'b0;
            ram_we <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (inta) begin
                        D_out <= INT_VECTOR;
                        D_oe  <= 1'b1;
                        state <= StHold;
                    end else if (mrd || mwr) begin
                        ram_addr <= A;
                        isRead   <= mrd;
                        if (mrd) begin
                            ram_re <= 1'b1;
                        end else begin
                            ram_we    <= 1'b1;
                            ram_wdata <= D_in;
                        end
                        if (MEM_WAIT > 0) begin
                            nWAIT <= 1'b0;
                            wcnt  <= WaitInit;
                            state <= StMemWait;
                        end else begin
                            state <= mrd ? StRdLat : StHold;
                        end
                    end else if (iord || iowr) begin
                        io_req   <= 1'b1;
                        io_wr    <= !iord;
                        io_addr  <= A[7:0];
                        io_wdata <= D_in;
                        isRead   <= iord;
                        nWAIT    <= 1'b0;
                        timer    <= TimeoutInit;
                        state    <= StIo;
                    end
                end
                StMemWait: begin
                    wcnt <= wcnt - 4'd1;
                    if (wcnt == 4'd1) begin
                        nWAIT <= 1'b1;
                        state <= isRead ? StRdLat : StHold;
                    end
                end
                StRdLat: begin
                    // With no wait states the RAM has not produced data yet while ram_re is high.
                    if (!ram_re) begin
                        D_out <= ram_rdata;
                        D_oe  <= 1'b1;
                        state <= StHold;
                    end
                end
                StIo: begin
                    timer <= timer - 8'd1;
                    if (io_ack) begin
                        io_req <= 1'b0;
                        io_wr  <= 1'b0;
                        nWAIT  <= 1'b1;
                        if (isRead) begin
                            D_out <= io_rdata;
                            D_oe  <= 1'b1;
                        end
                        state <= StHold;
                    end else if (timer == 8'd1) begin
                        io_req <= 1'b0;
                        io_wr  <= 1'b0;
                        nWAIT  <= 1'b1;
                        if (isRead) begin
                            D_out <= 8'hFF;
                            D_oe  <= 1'b1;
                        end
                        state <= StHold;
                    end
                end
                StHold: begin
                    if (nRD && nIORQ) begin
                        D_oe <= 1'b0;
                    end
                    if (busIdle) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_z80_bus_bridge.sv
// Scoreboard bench for z80_bus_bridge: two instances (no memory waits / two memory waits)
// share one CPU bus; expected bus events are queued per instance and popped by a monitor.
module tb_z80_bus_bridge;

    localparam logic [2:0] KRamRd = 3'd0;
    localparam logic [2:0] KRamWr = 3'd1;
    localparam logic [2:0] KIo    = 3'd2;
    localparam logic [2:0] KWait  = 3'd3;
    localparam logic [2:0] KDrive = 3'd4;

    typedef struct packed {
        logic [2:0]  kind;
        logic [15:0] addr;
        logic [7:0]  data;
    } txnT;

    logic        CLK;
    logic        nRESET;
    logic [15:0] A;
    logic [7:0]  D_in;
    logic        nM1, nMREQ, nIORQ, nRD, nWR, nRFSH;
    logic [7:0]  ioRdata;
    logic        ioAck;

    logic [1:0][7:0]  dOut, ramWdata, ramRdata, ioAddr, ioWdata;
    logic [1:0][15:0] ramAddr;
    logic [1:0]       dOe, nWait, ramRe, ramWe, ioReq, ioWr;

    int  compared   = 0;
    int  mismatched = 0;
    int  ackDelay   = 0;
    int  ackCnt     = 0;
    txnT q0[$];
    txnT q1[$];

    z80_bus_bridge #(.MEM_WAIT(0), .IO_TIMEOUT(16), .INT_VECTOR(8'hE7)) dut0 (
        .CLK(CLK), .nRESET(nRESET), .A(A), .D_in(D_in), .D_out(dOut[0]), .D_oe(dOe[0]),
        .nM1(nM1), .nMREQ(nMREQ), .nIORQ(nIORQ), .nRD(nRD), .nWR(nWR), .nRFSH(nRFSH),
        .nWAIT(nWait[0]), .ram_addr(ramAddr[0]), .ram_re(ramRe[0]), .ram_we(ramWe[0]),
        .ram_wdata(ramWdata[0]), .ram_rdata(ramRdata[0]), .io_req(ioReq[0]), .io_wr(ioWr[0]),
        .io_addr(ioAddr[0]), .io_wdata(ioWdata[0]), .io_rdata(ioRdata), .io_ack(ioAck)
    );

    z80_bus_bridge #(.MEM_WAIT(2), .IO_TIMEOUT(16), .INT_VECTOR(8'hE7)) dut1 (
        .CLK(CLK), .nRESET(nRESET), .A(A), .D_in(D_in), .D_out(dOut[1]), .D_oe(dOe[1]),
        .nM1(nM1), .nMREQ(nMREQ), .nIORQ(nIORQ), .nRD(nRD), .nWR(nWR), .nRFSH(nRFSH),
        .nWAIT(nWait[1]), .ram_addr(ramAddr[1]), .ram_re(ramRe[1]), .ram_we(ramWe[1]),
        .ram_wdata(ramWdata[1]), .ram_rdata(ramRdata[1]), .io_req(ioReq[1]), .io_wr(ioWr[1]),
        .io_addr(ioAddr[1]), .io_wdata(ioWdata[1]), .io_rdata(ioRdata), .io_ack(ioAck)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Synchronous RAMs, one per instance, 1-cycle read latency.
    logic [7:0] mem0 [65536];
    logic [7:0] mem1 [65536];
    initial begin
        ramRdata = '0;
        mem0[16'h1234] = 8'hA5;
        mem1[16'h1234] = 8'hA5;
        forever begin
            @(posedge CLK);
            if (ramRe[0]) ramRdata[0] <= mem0[ramAddr[0]];
            if (ramWe[0]) mem0[ramAddr[0]] <= ramWdata[0];
            if (ramRe[1]) ramRdata[1] <= mem1[ramAddr[1]];
            if (ramWe[1]) mem1[ramAddr[1]] <= ramWdata[1];
        end
    end

    // Peripheral: single-cycle ack after ackDelay cycles of io_req (0 = never).
    initial begin
        ioAck = 1'b0;
        forever begin
            @(negedge CLK);
            if (ioAck) begin
                ioAck = 1'b0;
            end else if (ioReq[0] && ackDelay != 0) begin
                ackCnt++;
                if (ackCnt == ackDelay) ioAck = 1'b1;
            end
            if (!ioReq[0]) ackCnt = 0;
        end
    end

    function automatic txnT mk(input logic [2:0] k, input logic [15:0] a, input logic [7:0] d);
        txnT t;
        t.kind = k;
        t.addr = a;
        t.data = d;
        return t;
    endfunction

    function automatic string kindName(input logic [2:0] k);
        case (k)
            KRamRd:  return "ram_read";
            KRamWr:  return "ram_write";
            KIo:     return "io_request";
            KWait:   return "wait_length";
            KDrive:  return "bus_drive";
            default: return "unknown";
        endcase
    endfunction

    task automatic push(input int mask, input logic [2:0] k, input logic [15:0] a,
                        input logic [7:0] d);
        if (mask[0]) q0.push_back(mk(k, a, d));
        if (mask[1]) q1.push_back(mk(k, a, d));
    endtask

    task automatic observe(input int d, input txnT got);
        txnT e;
        bit  have;
        have = 1'b0;
        e    = '0;
        if (d == 0 && q0.size() > 0) begin
            e = q0.pop_front();
            have = 1'b1;
        end else if (d == 1 && q1.size() > 0) begin
            e = q1.pop_front();
            have = 1'b1;
        end
        compared++;
        if (!have) begin
            mismatched++;
            $display("FAIL dut%0d unexpected %s: addr=%h data=%h, expected no event",
                     d, kindName(got.kind), got.addr, got.data);
        end else if (got !== e) begin
            mismatched++;
            $display("FAIL dut%0d %s: got kind=%s addr=%h data=%h, expected addr=%h data=%h",
                     d, kindName(e.kind), kindName(got.kind), got.addr, got.data, e.addr, e.data);
        end
    endtask

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Monitor: turns DUT activity into events and checks them against the queues.
    int   waitRun [2];
    logic prevOe  [2];
    logic prevReq [2];
    initial begin
        for (int i = 0; i < 2; i++) begin
            waitRun[i] = 0;
            prevOe[i]  = 1'b0;
            prevReq[i] = 1'b0;
        end
        forever begin
            @(negedge CLK);
            for (int i = 0; i < 2; i++) begin
                if (ramRe[i]) observe(i, mk(KRamRd, ramAddr[i], 8'h00));
                if (ramWe[i]) observe(i, mk(KRamWr, ramAddr[i], ramWdata[i]));
                if (ioReq[i] && !prevReq[i]) begin
                    observe(i, mk(KIo, {7'd0, ioWr[i], ioAddr[i]},
                                  ioWr[i] ? ioWdata[i] : 8'h00));
                end
                if (!nWait[i]) begin
                    waitRun[i]++;
                end else if (waitRun[i] != 0) begin
                    observe(i, mk(KWait, 16'h0000, 8'(waitRun[i])));
                    waitRun[i] = 0;
                end
                if (dOe[i] && !prevOe[i]) observe(i, mk(KDrive, 16'h0000, dOut[i]));
                if (dOe[i] && !nWR) begin
                    compared++;
                    mismatched++;
                    $display("FAIL dut%0d drive during write: D_oe=1, expected 0", i);
                end
                prevReq[i] = ioReq[i];
                prevOe[i]  = dOe[i];
            end
        end
    end

    // CPU strobes held for at least minCyc cycles and until both nWAIT are released.
    task automatic cpuCycle(input logic [15:0] addr, input logic [7:0] data, input logic m1,
                            input logic mreq, input logic iorq, input logic rd, input logic wr,
                            input int minCyc);
        int n;
        @(posedge CLK);
        #1;
        A = addr; D_in = data;
        nM1 = m1; nMREQ = mreq; nIORQ = iorq; nRD = rd; nWR = wr;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while ((n < minCyc || !nWait[0] || !nWait[1]) && n < 200);
        if (n >= 200) begin
            compared++;
            mismatched++;
            $display("FAIL nWAIT release: still low after %0d cycles, expected release", n);
        end
    endtask

    task automatic cpuRelease();
        @(posedge CLK);
        #1;
        nM1 = 1'b1; nMREQ = 1'b1; nIORQ = 1'b1; nRD = 1'b1; nWR = 1'b1; nRFSH = 1'b1;
        repeat (3) @(posedge CLK);
    endtask

    initial begin
        nRESET = 1'b0;
        A = 16'h0000; D_in = 8'h00; ioRdata = 8'h00;
        nM1 = 1'b1; nMREQ = 1'b1; nIORQ = 1'b1; nRD = 1'b1; nWR = 1'b1; nRFSH = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("reset nWAIT dut%0d", i), 16'(nWait[i]), 16'h1);
            chk($sformatf("reset D_oe dut%0d", i), 16'(dOe[i]), 16'h0);
            chk($sformatf("reset D_out dut%0d", i), 16'(dOut[i]), 16'h0);
            chk($sformatf("reset strobes dut%0d", i),
                16'({ramRe[i], ramWe[i], ioReq[i], ioWr[i]}), 16'h0);
            chk($sformatf("reset ram_addr dut%0d", i), ramAddr[i], 16'h0);
            chk($sformatf("reset io_addr dut%0d", i), 16'(ioAddr[i]), 16'h0);
        end
        @(negedge CLK);
        nRESET = 1'b1;
        repeat (2) @(posedge CLK);

        // M1 fetch at 0x1234 followed by its refresh half.
        push(3, KRamRd, 16'h1234, 8'h00);
        push(2, KWait, 16'h0000, 8'd2);
        push(3, KDrive, 16'h0000, 8'hA5);
        cpuCycle(16'h1234, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5);
        @(posedge CLK);
        #1;
        nM1 = 1'b1; nRD = 1'b1; nRFSH = 1'b0; A = 16'h0042;
        repeat (2) @(negedge CLK);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("D_oe after nRD rise dut%0d", i), 16'(dOe[i]), 16'h0);
        end
        cpuRelease();

        // Stand-alone refresh from idle: no access expected.
        @(posedge CLK);
        #1;
        A = 16'h0077; nMREQ = 1'b0; nRFSH = 1'b0;
        repeat (3) @(posedge CLK);
        cpuRelease();

        // Memory write to the top address.
        push(3, KRamWr, 16'hFFFF, 8'h3C);
        push(2, KWait, 16'h0000, 8'd2);
        cpuCycle(16'hFFFF, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4);
        cpuRelease();

        // OUT (0x7F),0x55 acked after 3 cycles.
        ackDelay = 3;
        push(3, KIo, 16'h017F, 8'h55);
        push(3, KWait, 16'h0000, 8'd3);
        cpuCycle(16'h557F, 8'h55, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3);
        cpuRelease();

        // IN from 0x10, never acked: timeout returns 0xFF.
        ackDelay = 0;
        ioRdata  = 8'h5A;
        push(3, KIo, 16'h0010, 8'h00);
        push(3, KWait, 16'h0000, 8'd16);
        push(3, KDrive, 16'h0000, 8'hFF);
        cpuCycle(16'h0010, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3);
        cpuRelease();

        // IN from 0x22 acked after 2 cycles.
        ackDelay = 2;
        ioRdata  = 8'hC3;
        push(3, KIo, 16'h0022, 8'h00);
        push(3, KWait, 16'h0000, 8'd2);
        push(3, KDrive, 16'h0000, 8'hC3);
        cpuCycle(16'h0022, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3);
        cpuRelease();

        // Interrupt acknowledge.
        push(3, KDrive, 16'h0000, 8'hE7);
        cpuCycle(16'h0000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3);
        cpuRelease();

        // Reset in the middle of an unacknowledged I/O read.
        ackDelay = 0;
        push(3, KIo, 16'h0033, 8'h00);
        push(3, KWait, 16'h0000, 8'd3);
        @(posedge CLK);
        #1;
        A = 16'h0033; nIORQ = 1'b0; nRD = 1'b0;
        repeat (4) @(negedge CLK);
        #2;
        nRESET = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("async reset io_req dut%0d", i), 16'(ioReq[i]), 16'h0);
            chk($sformatf("async reset nWAIT dut%0d", i), 16'(nWait[i]), 16'h1);
            chk($sformatf("async reset D_oe dut%0d", i), 16'(dOe[i]), 16'h0);
        end
        nIORQ = 1'b1; nRD = 1'b1;
        repeat (2) @(negedge CLK);
        nRESET = 1'b1;
        repeat (5) @(posedge CLK);

        chk("dut0 pending events", 16'(q0.size()), 16'h0);
        chk("dut1 pending events", 16'(q1.size()), 16'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
